// File: rtl/abc_pattern_gen.sv
// Steps {a,b,c} through 000..111, holding each combination HOLD_CYCLES clocks; optional looping and pause.
// Latency: outputs are registered, so each change shows one cycle after the edge that decided it. Backpressure: pause freezes the sweep.
module abc_pattern_gen #(
    parameter int HOLD_CYCLES = 200,
    parameter int CNT_W       = 8
) (
    input  logic       Clock,
    input  logic       Rst,
    input  logic       start,
    input  logic       pause,
    input  logic       loop,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] idx,
    output logic       step,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter only ever reaches HOLD_CYCLES-1, so HOLD_CYCLES = 2^CNT_W still fits.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'd7;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             step_q, step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        step_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (start) begin
                    state_d = S_RUN;
                    step_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            S_RUN: begin
                busy_d = 1'b1;
                // A paused final count defers the loop/finish decision to the releasing edge.
                if (!pause) begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (idx_q != IDX_LAST) begin
                            idx_d  = idx_q + 3'd1;
                            step_d = 1'b1;
                        end else if (loop) begin
                            idx_d  = 3'd0;
                            step_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                            idx_d   = 3'd0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a    = idx_q[2];
    assign b    = idx_q[1];
    assign c    = idx_q[0];
    assign idx  = idx_q;
    assign step = step_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
